// File: rtl/mc_main_controller_if.sv
// Control bus between the multicycle main controller and the datapath/condlogic.
// master = controller side, slave = datapath side.
interface mc_main_controller_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCS;
  logic [1:0] FlagW;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic       MemFault;

  modport master (
    input  Op, Funct, Rd, MemReady,
    output IRWrite, NextPC, RegW, MemW, PCS, FlagW, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, MemFault
  );

  modport slave (
    output Op, Funct, Rd, MemReady,
    input  IRWrite, NextPC, RegW, MemW, PCS, FlagW, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, MemFault
  );
endinterface

// File: rtl/mc_main_controller.sv
// Multicycle main controller: instruction-sequencing FSM plus ALU decoder.
// Define MEM_HANDSHAKE_EN to enable MemReady stalls, the wait-timeout counter and MemFault.
module mc_main_controller #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_main_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam int         CNT_W   = $clog2(WAIT_LIMIT) + 1;

  state_t     state, state_nx;
  logic       ready, timeout;
  logic [3:0] cmd;

  logic       irwrite, nextpc, regw, memw, pcs, adrsrc, memfault;
  logic [1:0] flagw, resultsrc, alusrca, alusrcb, aluctl;

  assign cmd = bus.Funct[4:1];

  function automatic logic [1:0] alu_ctl(input logic [3:0] c);
    case (c)
      CMD_SUB, CMD_CMP: return 2'b01;
      CMD_AND:          return 2'b10;
      CMD_ORR:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic alu_writes(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_AND) || (c == CMD_ORR);
  endfunction

  // CMP always updates flags; only arithmetic ops touch C/V.
  function automatic logic [1:0] flag_req(input logic [3:0] c, input logic s);
    logic s_eff;
    s_eff = s | (c == CMD_CMP);
    return {s_eff, s_eff & ((c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_CMP))};
  endfunction

`ifdef MEM_HANDSHAKE_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;

  assign in_wait = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign ready   = bus.MemReady;
  assign timeout = in_wait && !bus.MemReady && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
`else
  logic             unused_memready;
  logic [CNT_W-1:0] unused_cnt;

  assign unused_memready = bus.MemReady;
  assign unused_cnt      = '0;
  assign ready           = 1'b1;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (ready) state_nx = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_nx = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR: state_nx = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD: begin
        if (ready)        state_nx = MEMWB;
        else if (timeout) state_nx = FETCH;
      end
      MEMWR:  if (ready || timeout) state_nx = FETCH;
      EXECR, EXECI: state_nx = alu_writes(cmd) ? ALUWB : FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
`ifdef MEM_HANDSHAKE_EN
      wait_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
`ifdef MEM_HANDSHAKE_EN
      // Counter tracks consecutive stalled cycles in the current wait state only.
      if (!in_wait || ready || timeout || (state_nx != state)) wait_cnt <= '0;
      else                                                    wait_cnt <= wait_cnt + 1'b1;
`endif
    end
  end

  always_comb begin
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    pcs       = 1'b0;
    flagw     = 2'b00;
    adrsrc    = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluctl    = 2'b00;
    memfault  = timeout;
    case (state)
      FETCH: begin
        irwrite   = ready;
        nextpc    = ready;
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
      end
      MEMADR: alusrcb = 2'b01;
      MEMRD:  adrsrc = 1'b1;
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
        pcs       = (bus.Rd == 4'hF);
      end
      EXECR, EXECI: begin
        alusrcb = (state == EXECI) ? 2'b01 : 2'b00;
        aluctl  = alu_ctl(cmd);
        flagw   = flag_req(cmd, bus.Funct[0]);
      end
      ALUWB: begin
        regw = 1'b1;
        pcs  = (bus.Rd == 4'hF);
      end
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        pcs       = 1'b1;
      end
      default: ;
    endcase
    // Reset wins combinationally so no write request escapes in the reset cycle.
    if (reset) begin
      irwrite   = 1'b0;
      nextpc    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      pcs       = 1'b0;
      flagw     = 2'b00;
      adrsrc    = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluctl    = 2'b00;
      memfault  = 1'b0;
    end
  end

  assign bus.IRWrite    = irwrite;
  assign bus.NextPC     = nextpc;
  assign bus.RegW       = regw;
  assign bus.MemW       = memw;
  assign bus.PCS        = pcs;
  assign bus.FlagW      = flagw;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUControl = aluctl;
  assign bus.MemFault   = memfault;
endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: per-cycle output check against an instruction-level reference model.
module tb_mc_main_controller;
  localparam int WL = 8;
`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef struct packed {
    logic       irw, npc, regw, memw, pcs;
    logic [1:0] flagw;
    logic       adr;
    logic [1:0] res, srca, srcb, aluc;
    logic       fault;
  } ov_t;

  logic clk = 1'b0;
  logic reset;
  int   nerr = 0;
  int   nchk = 0;

  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  logic [3:0] cur_rd;

  logic [1:0] aluc_tbl [16];
  bit         wb_tbl   [16];
  bit         arith_tbl[16];

  mc_main_controller_if bus ();

  mc_main_controller #(.WAIT_LIMIT(WL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ov_t sample();
    ov_t o;
    o.irw   = bus.IRWrite;
    o.npc   = bus.NextPC;
    o.regw  = bus.RegW;
    o.memw  = bus.MemW;
    o.pcs   = bus.PCS;
    o.flagw = bus.FlagW;
    o.adr   = bus.AdrSrc;
    o.res   = bus.ResultSrc;
    o.srca  = bus.ALUSrcA;
    o.srcb  = bus.ALUSrcB;
    o.aluc  = bus.ALUControl;
    o.fault = bus.MemFault;
    return o;
  endfunction

  task automatic chk(input ov_t e, input string tag);
    ov_t got;
    got = sample();
    nchk++;
    assert (got === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h (op=%b funct=%b rd=%h)", tag, got, e, cur_op, cur_funct, cur_rd);
    end
  endtask

  task automatic step(input logic mr, input ov_t e, input string tag);
    @(negedge clk);
    bus.Op       = cur_op;
    bus.Funct    = cur_funct;
    bus.Rd       = cur_rd;
    bus.MemReady = mr;
    #1;
    chk(e, tag);
  endtask

  // A memory-facing phase: nwait stalled cycles are offered before MemReady goes high.
  task automatic mem_phase(input ov_t base, input bit is_fetch, input int nwait,
                           input string tag, output bit ok);
    int  cnt;
    int  k;
    bit  mr, eff, flt;
    ov_t e;
    cnt = 0;
    k   = 0;
    ok  = 1'b0;
    forever begin
      mr  = (k >= nwait);
      eff = HS ? mr : 1'b1;
      flt = HS && !eff && (cnt == WL - 1);
      e       = base;
      e.fault = flt;
      if (is_fetch) begin
        e.irw = eff;
        e.npc = eff;
      end
      step(mr, e, tag);
      k++;
      if (eff) begin
        ok = 1'b1;
        return;
      end
      if (flt) begin
        if (!is_fetch) return;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  endtask

  task automatic fetch_decode(input int fw, input string tag);
    ov_t e;
    bit  ok;
    e      = '0;
    e.srca = 2'b01;
    e.srcb = 2'b10;
    e.res  = 2'b10;
    mem_phase(e, 1'b1, fw, {tag, ".fetch"}, ok);
    e      = '0;
    e.srca = 2'b01;
    e.srcb = 2'b10;
    step(1'($urandom_range(0, 1)), e, {tag, ".decode"});
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input int fw, input int mw, input string tag);
    ov_t        e;
    bit         ok, seff;
    logic [3:0] c;
    cur_op    = op;
    cur_funct = funct;
    cur_rd    = rd;
    c         = funct[4:1];
    fetch_decode(fw, tag);
    case (op)
      2'b00: begin
        seff    = funct[0] | (c == 4'b1010);
        e       = '0;
        e.srcb  = funct[5] ? 2'b01 : 2'b00;
        e.aluc  = aluc_tbl[c];
        e.flagw = {seff, seff & arith_tbl[c]};
        step(1'($urandom_range(0, 1)), e, {tag, ".exec"});
        if (wb_tbl[c]) begin
          e      = '0;
          e.regw = 1'b1;
          e.pcs  = (rd == 4'hF);
          step(1'($urandom_range(0, 1)), e, {tag, ".aluwb"});
        end
      end
      2'b01: begin
        e      = '0;
        e.srcb = 2'b01;
        step(1'($urandom_range(0, 1)), e, {tag, ".memadr"});
        e     = '0;
        e.adr = 1'b1;
        if (funct[0]) begin
          mem_phase(e, 1'b0, mw, {tag, ".memrd"}, ok);
          if (ok) begin
            e      = '0;
            e.res  = 2'b01;
            e.regw = 1'b1;
            e.pcs  = (rd == 4'hF);
            step(1'($urandom_range(0, 1)), e, {tag, ".memwb"});
          end
        end else begin
          e.memw = 1'b1;
          mem_phase(e, 1'b0, mw, {tag, ".memwr"}, ok);
        end
      end
      2'b10: begin
        e      = '0;
        e.srcb = 2'b01;
        e.res  = 2'b10;
        e.pcs  = 1'b1;
        step(1'($urandom_range(0, 1)), e, {tag, ".branch"});
      end
      default: ;
    endcase
  endtask

  // Assert reset for the current cycle, expect silence, and release after the edge.
  task automatic reset_cycle(input string tag);
    @(negedge clk);
    reset        = 1'b1;
    bus.MemReady = 1'b1;
    #1;
    chk('0, tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      aluc_tbl[i]  = 2'b00;
      wb_tbl[i]    = 1'b0;
      arith_tbl[i] = 1'b0;
    end
    aluc_tbl[4'b0100] = 2'b00; wb_tbl[4'b0100] = 1'b1; arith_tbl[4'b0100] = 1'b1;
    aluc_tbl[4'b0010] = 2'b01; wb_tbl[4'b0010] = 1'b1; arith_tbl[4'b0010] = 1'b1;
    aluc_tbl[4'b0000] = 2'b10; wb_tbl[4'b0000] = 1'b1;
    aluc_tbl[4'b1100] = 2'b11; wb_tbl[4'b1100] = 1'b1;
    aluc_tbl[4'b1010] = 2'b01;                          arith_tbl[4'b1010] = 1'b1;

    cur_op    = 2'b01;
    cur_funct = 6'b000000;
    cur_rd    = 4'hF;
    reset     = 1'b1;
    bus.Op       = cur_op;
    bus.Funct    = cur_funct;
    bus.Rd       = cur_rd;
    bus.MemReady = 1'b1;
    step(1'b1, '0, "reset0");
    step(1'b1, '0, "reset1");
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(2'b00, 6'b001000, 4'h1, 0, 0, "add");
    run_instr(2'b00, 6'b100101, 4'hF, 0, 0, "subs_pc");
    run_instr(2'b00, 6'b010101, 4'h3, 0, 0, "cmp");
    run_instr(2'b01, 6'b011001, 4'h2, 0, 3, "ldr_wait3");
    run_instr(2'b01, 6'b011000, 4'h2, 0, 1000, "str_stuck");
    run_instr(2'b01, 6'b011001, 4'h5, 0, 1000, "ldr_stuck");
    run_instr(2'b01, 6'b011001, 4'hF, WL - 1, WL - 1, "ldr_limit_ready");
    run_instr(2'b01, 6'b011000, 4'h4, 0, WL - 1, "str_limit_ready");
    run_instr(2'b00, 6'b000000, 4'h6, WL + 3, 0, "and_fetch_abort");
    run_instr(2'b11, 6'b111111, 4'hF, 0, 0, "undef");
    run_instr(2'b00, 6'b011111, 4'h7, 0, 0, "unknown_cmd");

    cur_op    = 2'b10;
    cur_funct = 6'b000000;
    cur_rd    = 4'h0;
    fetch_decode(0, "br_rst");
    reset_cycle("br_rst.reset_in_branch");

    cur_op    = 2'b01;
    cur_funct = 6'b000000;
    fetch_decode(1, "str_rst");
    step(1'b0, ov_t'{srcb: 2'b01, default: '0}, "str_rst.memadr");
    reset_cycle("str_rst.reset_in_memwr");

    for (int n = 0; n < 300; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2 * WL)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2 * WL)) : int'($urandom_range(0, 3));
      run_instr(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), fw, mw, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
